// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester writeback arbiter with a registered register-file port
// and a busy-register scoreboard. Round-robin priority flips only on a grant.
`default_nettype none

module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  // requester A (EXU)
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_wd,
  input  logic        a_reg_en,
  input  logic [31:0] a_pc,
  // requester B (LSU)
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_wd,
  input  logic        b_reg_en,
  input  logic [31:0] b_pc,
  input  logic        wb_stall,
  // register-file port
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wd,
  output logic        wb_reg_en,
  output logic [31:0] wb_pc,
  // scoreboard allocate and hazard query
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic        sb_err
);

  logic        r_prio;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_wd;
  logic        r_wb_reg_en;
  logic [31:0] r_wb_pc;
  logic [31:0] r_busy;
  logic        r_sb_err;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_set;
  logic        w_clr;
  logic        w_err;
  logic [31:0] w_busy_nxt;

  // Readies are gated by rst so that nothing is accepted while reset is held.
  assign w_grant_a = rst && !wb_stall && a_valid && (!b_valid || !r_prio);
  assign w_grant_b = rst && !wb_stall && b_valid && (!a_valid ||  r_prio);
  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;

  assign w_set = alloc_valid && (alloc_rd != 5'd0);
  assign w_clr = r_wb_valid && r_wb_reg_en && (r_wb_rd != 5'd0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[r_wb_rd] = 1'b0;
    if (w_set) w_busy_nxt[alloc_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // A same-edge clear of the allocated index makes a re-allocation legal.
  assign w_err = (w_set && r_busy[alloc_rd] && !(w_clr && (r_wb_rd == alloc_rd)))
              || (w_clr && !r_busy[r_wb_rd]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio      <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_wd     <= 32'd0;
      r_wb_reg_en <= 1'b0;
      r_wb_pc     <= 32'd0;
      r_busy      <= 32'd0;
      r_sb_err    <= 1'b0;
    end else begin
      r_wb_valid <= w_grant_a || w_grant_b;
      if (w_grant_a) begin
        r_prio      <= 1'b1;
        r_wb_rd     <= a_rd;
        r_wb_wd     <= a_wd;
        r_wb_reg_en <= a_reg_en;
        r_wb_pc     <= a_pc;
      end else if (w_grant_b) begin
        r_prio      <= 1'b0;
        r_wb_rd     <= b_rd;
        r_wb_wd     <= b_wd;
        r_wb_reg_en <= b_reg_en;
        r_wb_pc     <= b_pc;
      end
      r_busy <= w_busy_nxt;
      if (w_err) r_sb_err <= 1'b1;
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_wd     = r_wb_wd;
  assign wb_reg_en = r_wb_reg_en;
  assign wb_pc     = r_wb_pc;
  assign sb_err    = r_sb_err;
  assign rs1_busy  = r_busy[chk_rs1];
  assign rs2_busy  = r_busy[chk_rs2];
  assign rd_busy   = r_busy[chk_rd];

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic checked against a
// behavioural model of the arbiter and scoreboard.
`default_nettype none

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_reg_en, b_valid, b_reg_en, wb_stall, alloc_valid;
  logic [4:0]  a_rd, b_rd, alloc_rd, chk_rs1, chk_rs2, chk_rd;
  logic [31:0] a_wd, a_pc, b_wd, b_pc;
  logic        a_ready, b_ready, wb_valid, wb_reg_en, rs1_busy, rs2_busy, rd_busy, sb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd, wb_pc;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wd(a_wd), .a_reg_en(a_reg_en), .a_pc(a_pc),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wd(b_wd), .b_reg_en(b_reg_en), .b_pc(b_pc),
    .wb_stall(wb_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_reg_en(wb_reg_en), .wb_pc(wb_pc),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit        m_busy [32];
  int        m_prio;          // side that wins a tie: 0 = A, 1 = B
  bit        m_valid, m_en, m_err;
  int        m_rd;
  bit [31:0] m_wd, m_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_prio = 0; m_valid = 0; m_en = 0; m_err = 0; m_rd = 0; m_wd = 0; m_pc = 0;
  endtask

  // Which side the arbitration rules pick: -1 none, 0 A, 1 B.
  function automatic int winner();
    if (rst !== 1'b1 || wb_stall) return -1;
    if (a_valid && b_valid) return m_prio;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  function automatic bit busy_of(input logic [4:0] idx);
    return (idx == 0) ? 1'b0 : m_busy[idx];
  endfunction

  task automatic model_edge();
    int w;
    int clr_idx;
    w = winner();
    clr_idx = (m_valid && m_en && m_rd != 0) ? m_rd : -1;
    if (clr_idx > 0 && !m_busy[clr_idx]) m_err = 1;
    if (alloc_valid && alloc_rd != 0 && m_busy[alloc_rd] && clr_idx != int'(alloc_rd)) m_err = 1;
    if (clr_idx > 0) m_busy[clr_idx] = 0;
    if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1;
    m_valid = (w >= 0);
    if (w == 0) begin m_rd = a_rd; m_wd = a_wd; m_en = a_reg_en; m_pc = a_pc; m_prio = 1; end
    if (w == 1) begin m_rd = b_rd; m_wd = b_wd; m_en = b_reg_en; m_pc = b_pc; m_prio = 0; end
  endtask

  task automatic check_comb();
    int w;
    w = winner();
    check("a_ready", a_ready, w == 0);
    check("b_ready", b_ready, w == 1);
    check("rs1_busy", rs1_busy, busy_of(chk_rs1));
    check("rs2_busy", rs2_busy, busy_of(chk_rs2));
    check("rd_busy",  rd_busy,  busy_of(chk_rd));
  endtask

  task automatic check_regs();
    check("wb_valid",  wb_valid,  m_valid);
    check("wb_rd",     wb_rd,     m_rd);
    check("wb_wd",     wb_wd,     m_wd);
    check("wb_reg_en", wb_reg_en, m_en);
    check("wb_pc",     wb_pc,     m_pc);
    check("sb_err",    sb_err,    m_err);
  endtask

  // One clock: inputs are already applied; compare combinational outputs, step
  // the model on the edge, then compare the registered outputs.
  task automatic tick();
    #1 check_comb();
    @(posedge clk);
    if (rst) model_edge();
    #1 check_regs();
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; wb_stall = 0; alloc_valid = 0;
    a_reg_en = 0; b_reg_en = 0;
  endtask

  task automatic hard_reset();
    rst = 0; model_reset();
    idle();
    tick();
    rst = 1;
  endtask

  initial begin
    rst = 0; model_reset(); idle();
    a_rd = 0; b_rd = 0; a_wd = 0; b_wd = 0; a_pc = 0; b_pc = 0;
    alloc_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;

    // Held in reset with a request pending: nothing granted, outputs cleared.
    a_valid = 1;
    tick();
    check("reset_wb_valid", wb_valid, 1'b0);

    // Single A transfer right after release.
    rst = 1;
    a_valid = 1; a_rd = 5; a_wd = 32'h1234; a_reg_en = 1; a_pc = 32'h100; b_valid = 0;
    #1 check("first_a_ready", a_ready, 1'b1);
    tick();
    idle();
    check("first_wb_valid", wb_valid, 1'b1);
    check("first_wb_rd", wb_rd, 5'd5);
    check("first_wb_wd", wb_wd, 32'h1234);
    tick();

    // Both valid for four cycles: strict alternation, continuous wb_valid.
    hard_reset();
    a_valid = 1; b_valid = 1; a_reg_en = 0; b_reg_en = 0;
    for (int i = 0; i < 4; i++) begin
      a_wd = 32'hA0 + i; b_wd = 32'hB0 + i;
      #1 check("alt_a_ready", a_ready, (i % 2) == 0);
      tick();
      check("alt_wb_valid", wb_valid, 1'b1);
      check("alt_wb_wd", wb_wd, ((i % 2) == 0) ? 32'hA0 + i : 32'hB0 + i);
    end
    idle();
    tick();
    check("alt_end_valid", wb_valid, 1'b0);

    // Allocate r7, then B retires it.
    alloc_valid = 1; alloc_rd = 7;
    tick();
    alloc_valid = 0; chk_rs1 = 7;
    b_valid = 1; b_rd = 7; b_wd = 32'h77; b_reg_en = 1;
    #1 check("r7_busy", rs1_busy, 1'b1);
    tick();
    idle();
    #1 check("r7_busy_during_wb", rs1_busy, 1'b1);
    tick();
    #1 check("r7_cleared", rs1_busy, 1'b0);
    check("r7_no_err", sb_err, 1'b0);

    // Same-edge clear and re-allocate of r3.
    alloc_valid = 1; alloc_rd = 3;
    tick();
    alloc_valid = 0;
    a_valid = 1; a_rd = 3; a_reg_en = 1;
    tick();
    idle();
    alloc_valid = 1; alloc_rd = 3; chk_rs2 = 3;
    tick();
    alloc_valid = 0;
    #1 check("r3_still_busy", rs2_busy, 1'b1);
    check("r3_no_err", sb_err, 1'b0);

    // Stall with both requesters valid, then a write of a non-busy register.
    hard_reset();
    a_valid = 1; b_valid = 1; wb_stall = 1;
    #1 check("stall_a_ready", a_ready, 1'b0);
    check("stall_b_ready", b_ready, 1'b0);
    tick();
    check("stall_wb_valid", wb_valid, 1'b0);
    wb_stall = 0;
    #1 check("stall_prio_held", a_ready, 1'b1);
    b_valid = 0; a_rd = 9; a_reg_en = 1;
    tick();
    idle();
    tick();
    check("r9_err", sb_err, 1'b1);
    tick(); tick();
    check("r9_err_sticky", sb_err, 1'b1);

    // Asynchronous reset while a write is in flight and r4 is busy.
    hard_reset();
    alloc_valid = 1; alloc_rd = 4;
    tick();
    alloc_valid = 0; a_valid = 1; a_rd = 4; a_reg_en = 1; chk_rd = 4;
    tick();
    idle();
    #2 rst = 0; model_reset();
    #1 check("async_wb_valid", wb_valid, 1'b0);
    check("async_r4", rd_busy, 1'b0);
    tick();
    rst = 1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      a_valid = ($urandom_range(0, 2) != 0); b_valid = ($urandom_range(0, 2) != 0);
      wb_stall = ($urandom_range(0, 7) == 0);
      a_rd = 5'($urandom); b_rd = 5'($urandom);
      a_wd = $urandom; b_wd = $urandom; a_pc = $urandom; b_pc = $urandom;
      a_reg_en = 1'($urandom); b_reg_en = 1'($urandom);
      alloc_valid = ($urandom_range(0, 3) == 0); alloc_rd = 5'($urandom);
      chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom); chk_rd = 5'($urandom);
      if (i == 200) begin
        rst = 0; model_reset();
      end else if (i == 201) begin
        rst = 1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have requester A (EXU): a_valid in 1; a_ready out 1; a_rd in 5; a_wd in 32; a_reg_en in 1; a_pc in 32.
REQ-004 SHALL have requester B (LSU): b_valid in 1; b_ready out 1; b_rd in 5; b_wd in 32; b_reg_en in 1; b_pc in 32.
REQ-005 SHALL have: wb_stall  in  1  when high, no grant this cycle.
REQ-006 SHALL have register-file port: wb_valid out 1; wb_rd out 5; wb_wd out 32; wb_reg_en out 1; wb_pc out 32. wb_valid drives the register file's receive_valid.
REQ-007 SHALL have scoreboard allocate port: alloc_valid in 1; alloc_rd in 5.
REQ-008 SHALL have hazard query: chk_rs1 in 5; chk_rs2 in 5; chk_rd in 5; rs1_busy out 1; rs2_busy out 1; rd_busy out 1.
REQ-009 SHALL have: sb_err  out 1  sticky scoreboard-violation flag.

Function
REQ-010 Handshake: requester transfer occurs in a cycle where x_valid && x_ready; x_ready combinational, at most one of a_ready/b_ready high per cycle.
REQ-011 x_ready SHALL be 0 whenever wb_stall=1 or x_valid=0.
REQ-012 Arbitration: only A valid -> grant A; only B valid -> grant B; both valid -> grant side selected by prio (0=A, 1=B).
REQ-013 prio SHALL update only on a grant: grant A -> prio=1; grant B -> prio=0; no grant -> hold.
REQ-014 Output stage registered, latency 1: on grant, next edge loads wb_rd/wb_wd/wb_reg_en/wb_pc from granted side and sets wb_valid=1.
REQ-015 No grant -> wb_valid=0 next cycle; wb_rd/wb_wd/wb_reg_en/wb_pc hold last values.
REQ-016 wb_valid SHALL be a single-cycle pulse per transfer; back-to-back grants give continuous wb_valid, one transfer per cycle, full throughput.
REQ-017 Scoreboard: busy[31:1] bits, busy[0] constant 0.
REQ-018 Set: alloc_valid=1 and alloc_rd!=0 -> busy[alloc_rd] set at next edge.
REQ-019 Clear: at edge where wb_valid=1 and wb_reg_en=1 and wb_rd!=0 -> busy[wb_rd] cleared (same edge the register file captures).
REQ-020 Simultaneous set and clear of same index SHALL leave bit set (new allocation wins).
REQ-021 rs1_busy/rs2_busy/rd_busy SHALL be combinational reads of busy[chk_*] (current registered state, no bypass); index 0 -> 0.
REQ-022 sb_err SHALL set and stay 1 on: alloc to an already-busy nonzero rd (without same-edge clear of it), or clear of a non-busy nonzero rd.
REQ-023 wb_reg_en=0 transfers SHALL still pulse wb_valid (pc/ebreak retirement) but SHALL not touch scoreboard.
REQ-024 wb_stall asserted mid-burst: no grant that cycle; pending wb_valid from previous grant still emitted; prio held.

Reset
REQ-025 rst low SHALL immediately force: wb_valid=0, wb_rd=0, wb_wd=0, wb_reg_en=0, wb_pc=0, prio=0, busy all 0, sb_err=0.
REQ-026 During reset a_ready=b_ready=0; reset mid-transfer discards in-flight output-stage content.
REQ-027 First rising edge after rst deassertion SHALL operate normally.

Verification
REQ-028 Reset release, a_valid=1 a_rd=5 a_wd=0x1234 a_reg_en=1 b_valid=0 -> a_ready=1 cycle 0; cycle 1 wb_valid=1 wb_rd=5 wb_wd=0x1234.
REQ-029 a_valid=b_valid=1 held 4 cycles after reset -> grants A,B,A,B; wb_valid high 4 consecutive cycles starting one cycle later.
REQ-030 alloc_valid=1 alloc_rd=7; next cycle chk_rs1=7 -> rs1_busy=1; B writes rd=7 -> busy clears at edge ending wb_valid cycle; rs1_busy=0 after; sb_err=0.
REQ-031 Same edge: wb_valid=1 wb_rd=3 wb_reg_en=1 and alloc_valid=1 alloc_rd=3 (busy[3]=1) -> busy[3] stays 1, sb_err stays 0.
REQ-032 wb_stall=1 with both valid -> a_ready=b_ready=0, wb_valid=0 next cycle, prio unchanged; write to non-busy rd=9 -> sb_err=1 and stays 1 until rst.
REQ-033 rst asserted asynchronously while wb_valid=1 and busy[4]=1 -> wb_valid=0, busy[4]=0 before next clock edge.
